// File: rtl/btn_token_pkg.sv
// Shared definitions for the button-change token transmitter: token layout,
// handshake FSM encoding and the token packing helper.
package btn_token_pkg;

  localparam int TOK_W     = 8;
  localparam int MASK_MSB  = 7;
  localparam int MASK_LSB  = 4;
  localparam int STATE_MSB = 3;
  localparam int STATE_LSB = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } fsm_state_t;

  function automatic logic [TOK_W-1:0] make_token(input logic [3:0] diff,
                                                 input logic [3:0] bout);
    logic [TOK_W-1:0] tok;
    tok = '0;
    tok[MASK_MSB:MASK_LSB]   = diff;
    tok[STATE_MSB:STATE_LSB] = bout;
    return tok;
  endfunction

endpackage

// File: rtl/token_fifo.sv
// Small synchronous FIFO with wrapping pointers and an occupancy counter.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module token_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_wr_en;
  logic             w_rd_en;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_rd_en = i_pop & ~o_empty;
  assign w_wr_en = i_push & (~o_full | w_rd_en);
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/btn_token_tx.sv
// Turns BOUT changes into {changed mask, new state} tokens, queues them and
// delivers each over a four-phase Send/Ack handshake with optional timeout.
module btn_token_tx
  import btn_token_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int TIMEOUT     = 1000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [3:0]       BOUT,
  input  logic             Ack_out_DDP,
  output logic             Send_in_DDP,
  output logic [TOK_W-1:0] Data_in_DDP,
  output logic             OVF,
  output logic             TMO,
  output logic             Busy
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [3:0]             r_prev_bout;
  logic [3:0]             w_diff;
  logic                   w_push;
  logic [TOK_W-1:0]       w_tok;
  logic [SYNC_STAGES-1:0] r_ack_sync;
  logic                   w_ack_s;
  logic                   w_full;
  logic                   w_empty;
  logic [TOK_W-1:0]       w_head;
  logic [AW:0]            w_count;
  fsm_state_t             r_state;
  fsm_state_t             w_state_next;
  logic                   w_pop;
  logic                   w_send_next;
  logic                   w_tmo_set;
  logic                   w_timeout;
  logic [CNT_W-1:0]       r_tmo_cnt;
  logic                   r_send;
  logic [TOK_W-1:0]       r_data;
  logic                   r_ovf;
  logic                   r_tmo;

  assign w_diff  = BOUT ^ r_prev_bout;
  assign w_push  = |w_diff;
  assign w_tok   = make_token(w_diff, BOUT);
  assign w_ack_s = r_ack_sync[SYNC_STAGES-1];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_prev_bout <= '0;
      r_ack_sync  <= '0;
    end else begin
      r_prev_bout <= BOUT;
      r_ack_sync  <= {r_ack_sync[SYNC_STAGES-2:0], Ack_out_DDP};
    end
  end

  token_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (TOK_W)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst_n (nRST),
    .i_push  (w_push),
    .i_wdata (w_tok),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Counter sits at TIMEOUT-1 on the cycle the abort takes effect.
  assign w_timeout = (TIMEOUT != 0) && (r_tmo_cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_send_next  = r_send;
    w_tmo_set    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty && !w_ack_s) begin
          w_pop        = 1'b1;
          w_send_next  = 1'b1;
          w_state_next = REQ;
        end
      end
      REQ: begin
        if (w_ack_s) begin
          w_send_next  = 1'b0;
          w_state_next = REL;
        end else if (w_timeout) begin
          w_send_next  = 1'b0;
          w_tmo_set    = 1'b1;
          w_state_next = IDLE;
        end
      end
      REL: begin
        if (!w_ack_s) begin
          w_state_next = IDLE;
        end else if (w_timeout) begin
          w_tmo_set    = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: begin
        w_send_next  = 1'b0;
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= IDLE;
      r_send    <= 1'b0;
      r_data    <= '0;
      r_ovf     <= 1'b0;
      r_tmo     <= 1'b0;
      r_tmo_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      r_send  <= w_send_next;
      if (w_pop) r_data <= w_head;
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
      if (w_tmo_set) r_tmo <= 1'b1;
      if (w_state_next != r_state) r_tmo_cnt <= '0;
      else if ((TIMEOUT != 0) && (r_state != IDLE)) r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign Send_in_DDP = r_send;
  assign Data_in_DDP = r_data;
  assign OVF         = r_ovf;
  assign TMO         = r_tmo;
  assign Busy        = (w_count != '0) | (r_state != IDLE);

endmodule
